button_conditioner: RTL and testbench

Conditions the five raw Basys3 pushbuttons (btnU, btnD, btnL, btnR, btnC) before they reach the per-task OLED drawing modules and the sub-task selection logic. Each button is synchronised, debounced by a per-button state machine, and turned into a clean level, single-cycle press and release pulses, and an auto-repeat pulse train while held. It runs in the 6.25 MHz OLED clock domain, so the task modules consume edges directly without local edge detectors.

---
 rtl/button_conditioner.sv | 157 +++++++++++++++
 tb/tb_button_conditioner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: per-button two-flop sync, debounce FSM, press/release
// pulses and hold-to-repeat pulse train. Each button has its own button_lane.

module button_lane #(
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int REPEAT_DELAY    = 3125000,
  parameter int REPEAT_PERIOD   = 625000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic press_nxt,
  output logic rel,
  output logic rpt
);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [DW-1:0] D_LAST        = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;
  typedef enum logic {DELAY, PERIOD} phase_t;

  state_t        state, state_nxt;
  phase_t        phase, phase_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic [RW-1:0] rcnt, rcnt_nxt;
  logic [1:0]    sync;
  logic          s, rel_nxt, rpt_nxt;

  assign s     = sync[1];
  assign level = (state == HELD) || (state == DEB_RELEASE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '0;
      state <= IDLE;
      phase <= DELAY;
      dcnt  <= '0;
      rcnt  <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
      rpt   <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      state <= state_nxt;
      phase <= phase_nxt;
      dcnt  <= dcnt_nxt;
      rcnt  <= rcnt_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
      rpt   <= rpt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    dcnt_nxt  = dcnt;
    rcnt_nxt  = rcnt;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    rpt_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_nxt = DEB_PRESS;
          dcnt_nxt  = DW'(1);
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          state_nxt = IDLE;
        end else if (dcnt == D_LAST) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
          rcnt_nxt  = '0;
          phase_nxt = DELAY;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_nxt = DEB_RELEASE;
          dcnt_nxt  = DW'(1);
        end else if (phase == DELAY && rcnt == R_DELAY_LAST) begin
          rpt_nxt   = 1'b1;
          rcnt_nxt  = '0;
          phase_nxt = PERIOD;
        end else if (phase == PERIOD && rcnt == R_PERIOD_LAST) begin
          rpt_nxt  = 1'b1;
          rcnt_nxt = '0;
        end else begin
          rcnt_nxt = rcnt + RW'(1);
        end
      end
      DEB_RELEASE: begin
        // rcnt/phase stay frozen here so a glitch only delays the repeat train
        if (s) begin
          state_nxt = HELD;
        end else if (dcnt == D_LAST) begin
          state_nxt = IDLE;
          rel_nxt   = 1'b1;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int REPEAT_DELAY    = 3125000,
  parameter int REPEAT_PERIOD   = 625000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);
  logic [N_BTN-1:0] press_nxt;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_lane
    button_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw       (btn_raw[gi]),
      .level     (btn_level[gi]),
      .press     (btn_press[gi]),
      .press_nxt (press_nxt[gi]),
      .rel       (btn_release[gi]),
      .rpt       (btn_repeat[gi])
    );
  end

  // Built from next-state press so it lands on the same edge as btn_press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) any_press <= 1'b0;
    else          any_press <= |press_nxt;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed stimulus pushes expected pulse events
// into a queue; a negedge monitor pops one per observed pulse cycle and compares.

module tb_button_conditioner;
  localparam int N = 5, DEB = 4, RD = 10, RP = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic         any_press;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int           cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
    logic [N-1:0] level;
    logic         any;
  } ev_t;
  ev_t exp_q[$];

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat),
    .any_press   (any_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [N-1:0] p, input logic [N-1:0] r,
                      input logic [N-1:0] t, input logic [N-1:0] l, input logic a);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.rpt = t; e.level = l; e.any = a;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
  endtask

  task automatic at(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every cycle with any pulse is one scoreboard comparison
  always @(negedge clk) begin
    ev_t e;
    if ((btn_press | btn_release | btn_repeat) != '0 || any_press) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event cyc=%0d press=%b rel=%b rpt=%b lvl=%b any=%b want=none",
                 cyc, btn_press, btn_release, btn_repeat, btn_level, any_press);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc == cyc && e.press === btn_press && e.rel === btn_release &&
            e.rpt === btn_repeat && e.level === btn_level && e.any === any_press)
          n_pass++;
        else
          $display("FAIL event got cyc=%0d press=%b rel=%b rpt=%b lvl=%b any=%b want cyc=%0d press=%b rel=%b rpt=%b lvl=%b any=%b",
                   cyc, btn_press, btn_release, btn_repeat, btn_level, any_press,
                   e.cyc, e.press, e.rel, e.rpt, e.level, e.any);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("rst_level", btn_level, '0);
    chk("rst_press", btn_press, '0);
    chk("rst_release", btn_release, '0);
    chk("rst_repeat", btn_repeat, '0);
    chk("rst_any", {4'b0, any_press}, '0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean press bit 0, repeats at +16/+19/+22, release 6 edges after raw falls
    c = cyc; btn_raw = 5'b00001;
    push(c+6,  5'b00001, '0, '0, 5'b00001, 1'b1);
    push(c+16, '0, '0, 5'b00001, 5'b00001, 1'b0);
    push(c+19, '0, '0, 5'b00001, 5'b00001, 1'b0);
    push(c+22, '0, '0, 5'b00001, 5'b00001, 1'b0);
    push(c+28, '0, 5'b00001, '0, '0, 1'b0);
    at(c+5);  chk("s1_level_before", btn_level, '0);
    at(c+10); chk("s1_level_held", btn_level, 5'b00001);
    at(c+22); btn_raw = '0;
    at(c+27); chk("s1_level_deb_rel", btn_level, 5'b00001);
    at(c+32);

    // Bouncy press 1,0,1,1,0 then steady 1
    c = cyc; btn_raw = 5'b00001;
    push(c+11, 5'b00001, '0, '0, 5'b00001, 1'b1);
    push(c+17, '0, 5'b00001, '0, '0, 1'b0);
    at(c+1); btn_raw = '0;
    at(c+2); btn_raw = 5'b00001;
    at(c+4); btn_raw = '0;
    at(c+5); btn_raw = 5'b00001;
    at(c+9); chk("s2_no_level_bounce", btn_level, '0);
    at(c+11); btn_raw = '0;
    at(c+20);

    // Bit 1: release glitch (raw low 2 cycles) delays repeat train, then clean release
    c = cyc; btn_raw = 5'b00010;
    push(c+6,  5'b00010, '0, '0, 5'b00010, 1'b1);
    push(c+16, '0, '0, 5'b00010, 5'b00010, 1'b0);
    push(c+22, '0, '0, 5'b00010, 5'b00010, 1'b0);
    push(c+25, '0, '0, 5'b00010, 5'b00010, 1'b0);
    push(c+31, '0, 5'b00010, '0, '0, 1'b0);
    at(c+16); btn_raw = '0;
    at(c+18); btn_raw = 5'b00010;
    at(c+20); chk("s3_glitch_level", btn_level, 5'b00010);
    at(c+25); btn_raw = '0;
    at(c+29); chk("s3_level_deb_rel", btn_level, 5'b00010);
    at(c+35);

    // Simultaneous press of bits 0 and 4
    c = cyc; btn_raw = 5'b10001;
    push(c+6,  5'b10001, '0, '0, 5'b10001, 1'b1);
    push(c+12, '0, 5'b10001, '0, '0, 1'b0);
    at(c+6); btn_raw = '0;
    at(c+7); chk("s4_any_single", {4'b0, any_press}, '0);
    at(c+15);

    // Asynchronous reset mid-hold, raw still high afterwards
    c = cyc; btn_raw = 5'b00100;
    push(c+6, 5'b00100, '0, '0, 5'b00100, 1'b1);
    at(c+10); chk("s5_level_held", btn_level, 5'b00100);
    #2 reset_n = 1'b0;
    #1;
    chk("s5_rst_level", btn_level, '0);
    chk("s5_rst_press", btn_press, '0);
    chk("s5_rst_release", btn_release, '0);
    chk("s5_rst_repeat", btn_repeat, '0);
    chk("s5_rst_any", {4'b0, any_press}, '0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1; c = cyc;
    push(c+6,  5'b00100, '0, '0, 5'b00100, 1'b1);
    push(c+12, '0, 5'b00100, '0, '0, 1'b0);
    at(c+5); chk("s5_level_before", btn_level, '0);
    at(c+6); btn_raw = '0;
    at(c+15);

    // Runt pulse: raw high 3 cycles on bit 3
    c = cyc; btn_raw = 5'b01000;
    at(c+3); btn_raw = '0;
    for (int i = 0; i < 8; i++) begin
      at(c+2+i); chk("s6_runt_level", btn_level, '0);
    end
    at(cyc+10);

    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL pending_events left=%0d want=0 next_cyc=%0d", exp_q.size(), exp_q[0].cyc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
